// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the pipeline MEM stage (default owner)
// and an external debug/loader requester that is granted one stall cycle per request.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EXT  = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic                ack_q;
  logic                stall_q;
  logic [DATA_W-1:0]   ext_rdata_q;
  logic                cpu_req;

  assign cpu_req = cpu_re | cpu_we;

  // stall_q is set on exactly the edges that enter S_EXT, so it mirrors the state without decode glitches.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      ack_q       <= 1'b0;
      stall_q     <= 1'b0;
      ext_rdata_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ext_req && !ack_q) begin
            if (cpu_req) begin
              state_q    <= S_WAIT;
              wait_cnt_q <= CNT_ONE;
            end else begin
              state_q <= S_EXT;
              stall_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!ext_req) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
          end else if (!cpu_req || wait_cnt_q == CNT_MAX) begin
            state_q <= S_EXT;
            stall_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_ONE;
          end
        end
        S_EXT: begin
          state_q     <= S_IDLE;
          wait_cnt_q  <= '0;
          ack_q       <= 1'b1;
          ext_rdata_q <= mem_rdata;
        end
        default: begin
          state_q    <= S_IDLE;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // A reset landing on the external slot must not leave a half-committed write behind.
  always_comb begin
    if (stall_q) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_we    = ext_we & ~reset_in;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end
  end

  assign cpu_rdata = mem_rdata;
  assign cpu_stall = stall_q;
  assign ext_ack   = ack_q;
  assign ext_rdata = ext_rdata_q;

endmodule
